// File: rtl/mdio_bit_engine.sv
// Clause 22 MDIO master: free-running MDC divider plus a frame serialiser that
// drives on MDC falling edges and samples on MDC rising edges.
module mdio_bit_engine #(
  parameter int MDC_DIV = 25,
  parameter int PRE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_exec,
  input  logic        op_rh_wl,
  input  logic [4:0]  phy_addr,
  input  logic [4:0]  op_addr,
  input  logic [15:0] op_wr_data,
  output logic        op_done,
  output logic [15:0] op_rd_data,
  output logic        op_rd_ack,
  output logic        eth_mdc,
  output logic        eth_mdio_o,
  output logic        eth_mdio_oe,
  input  logic        eth_mdio_i
);

  localparam int DIV_W = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;
  localparam int N     = PRE_LEN + 32;

  localparam logic [6:0] LAST_BIT  = 7'(N - 1);
  localparam logic [6:0] CMD_START = 7'(PRE_LEN);
  localparam logic [6:0] TA2_BIT   = 7'(PRE_LEN + 15);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_EDGE = 3'd1;
  localparam logic [2:0] S_PRE       = 3'd2;
  localparam logic [2:0] S_CMD       = 3'd3;
  localparam logic [2:0] S_TA        = 3'd4;
  localparam logic [2:0] S_DATA      = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  logic [DIV_W-1:0] div_cnt;
  logic             term_cnt;
  logic             fall_tick;
  logic             rise_tick;

  logic [2:0]  state;
  logic [6:0]  bit_cnt;
  logic        rd_q;
  logic [4:0]  phy_q;
  logic [4:0]  reg_q;
  logic [15:0] wdata_q;
  logic [15:0] shift_q;

  logic [31:0] cmd_word;
  logic [6:0]  next_bit;
  logic [6:0]  offset;
  logic [4:0]  cmd_sel;
  logic        next_o;
  logic        next_oe;
  logic [2:0]  next_state;

  assign term_cnt  = (div_cnt == DIV_W'(MDC_DIV - 1));
  assign fall_tick = term_cnt & eth_mdc;
  assign rise_tick = term_cnt & ~eth_mdc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      eth_mdc <= 1'b1;
    end else if (term_cnt) begin
      div_cnt <= '0;
      eth_mdc <= ~eth_mdc;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Everything after the preamble; read TA and data positions are released
  // to the PHY, so their drive values here never reach the wire.
  assign cmd_word = {2'b01, (rd_q ? 2'b10 : 2'b01), phy_q, reg_q, 2'b10, wdata_q};

  always_comb begin
    next_bit   = bit_cnt + 7'd1;
    offset     = next_bit - CMD_START;
    cmd_sel    = 5'(7'd31 - offset);
    next_o     = 1'b1;
    next_oe    = 1'b1;
    next_state = S_PRE;
    if (next_bit >= CMD_START) begin
      next_o = cmd_word[cmd_sel];
      if (offset < 7'd14) begin
        next_state = S_CMD;
      end else if (offset < 7'd16) begin
        next_state = S_TA;
      end else begin
        next_state = S_DATA;
      end
      if (rd_q && (offset >= 7'd14)) begin
        next_o  = 1'b1;
        next_oe = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      rd_q        <= 1'b0;
      phy_q       <= '0;
      reg_q       <= '0;
      wdata_q     <= '0;
      shift_q     <= '0;
      op_done     <= 1'b0;
      op_rd_data  <= 16'h0000;
      op_rd_ack   <= 1'b1;
      eth_mdio_o  <= 1'b1;
      eth_mdio_oe <= 1'b0;
    end else begin
      op_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (op_exec) begin
            rd_q    <= op_rh_wl;
            phy_q   <= phy_addr;
            reg_q   <= op_addr;
            wdata_q <= op_wr_data;
            state   <= S_WAIT_EDGE;
          end
        end
        S_WAIT_EDGE: begin
          if (fall_tick) begin
            bit_cnt     <= '0;
            eth_mdio_o  <= 1'b1;
            eth_mdio_oe <= 1'b1;
            state       <= S_PRE;
          end
        end
        S_PRE, S_CMD, S_TA, S_DATA: begin
          if (rise_tick && rd_q) begin
            if ((state == S_TA) && (bit_cnt == TA2_BIT)) begin
              op_rd_ack <= eth_mdio_i;
            end
            if (state == S_DATA) begin
              shift_q <= {shift_q[14:0], eth_mdio_i};
            end
          end
          if (fall_tick) begin
            if (bit_cnt == LAST_BIT) begin
              eth_mdio_o  <= 1'b1;
              eth_mdio_oe <= 1'b0;
              state       <= S_DONE;
            end else begin
              bit_cnt     <= next_bit;
              eth_mdio_o  <= next_o;
              eth_mdio_oe <= next_oe;
              state       <= next_state;
            end
          end
        end
        S_DONE: begin
          op_done <= 1'b1;
          state   <= S_IDLE;
          if (rd_q) begin
            op_rd_data <= shift_q;
          end else begin
            op_rd_ack <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_bit_engine.sv
// Self-checking bench for mdio_bit_engine: wire-level frame capture against a
// concatenated reference frame, with a simple PHY responder for reads.
module tb_mdio_bit_engine;

  localparam int MDC_DIV = 25;
  localparam int PRE     = 32;
  localparam int N       = PRE + 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_exec;
  logic        op_rh_wl;
  logic [4:0]  phy_addr;
  logic [4:0]  op_addr;
  logic [15:0] op_wr_data;
  logic        op_done;
  logic [15:0] op_rd_data;
  logic        op_rd_ack;
  logic        eth_mdc;
  logic        eth_mdio_o;
  logic        eth_mdio_oe;
  logic        eth_mdio_i;

  mdio_bit_engine #(.MDC_DIV(MDC_DIV), .PRE_LEN(PRE)) dut (
    .clk(clk), .rst_n(rst_n), .op_exec(op_exec), .op_rh_wl(op_rh_wl),
    .phy_addr(phy_addr), .op_addr(op_addr), .op_wr_data(op_wr_data),
    .op_done(op_done), .op_rd_data(op_rd_data), .op_rd_ack(op_rd_ack),
    .eth_mdc(eth_mdc), .eth_mdio_o(eth_mdio_o), .eth_mdio_oe(eth_mdio_oe),
    .eth_mdio_i(eth_mdio_i)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  int          frame_id = 0;
  logic        phy_present = 1'b0;
  logic [15:0] phy_data = 16'h0000;
  logic [15:0] exp_rd_data;
  logic        exp_rd_ack;

  int          mon_frame = 0;
  bit          active = 1'b0;
  int          fall_count = 0;
  int          done_count = 0;
  logic [63:0] obs_o = '0;
  logic [63:0] obs_oe = '0;
  int          cyc = 0;
  int          last_rise = -1;
  int          mdc_checks = 0;
  int          mdc_bad = 0;
  int          edge_bad = 0;
  int          tail_bad = 0;
  logic        prev_mdc, prev_o, prev_oe, prev_rst;

  function automatic logic phy_bit(input int i, input logic [15:0] d);
    if (i == PRE + 15) return 1'b0;
    if (i >= PRE + 16 && i < N) return d[15 - (i - PRE - 16)];
    return 1'b1;
  endfunction

  // Wire monitor and PHY responder, sampling 1ns after every clk edge.
  always @(posedge clk) begin
    #1;
    if (rst_n !== 1'b1) begin
      active     = 1'b0;
      eth_mdio_i = 1'b1;
      last_rise  = -1;
    end else begin
      if (frame_id != mon_frame) begin
        mon_frame  = frame_id;
        active     = 1'b1;
        fall_count = 0;
        done_count = 0;
        obs_o      = '0;
        obs_oe     = '0;
      end
      if (prev_mdc === 1'b1 && eth_mdc === 1'b0) begin
        if (last_rise >= 0) begin
          mdc_checks++;
          if (cyc - last_rise != MDC_DIV) mdc_bad++;
        end
        if (active) begin
          fall_count++;
          if (fall_count == N + 1 && (eth_mdio_oe !== 1'b0 || eth_mdio_o !== 1'b1)) tail_bad++;
        end
      end
      if (prev_mdc === 1'b0 && eth_mdc === 1'b1) begin
        if (last_rise >= 0) begin
          mdc_checks++;
          if (cyc - last_rise != 2 * MDC_DIV) mdc_bad++;
        end
        last_rise = cyc;
        if (active && fall_count >= 1 && fall_count <= N) begin
          obs_o[N - fall_count]  = eth_mdio_o;
          obs_oe[N - fall_count] = eth_mdio_oe;
        end
      end
      if (prev_rst === 1'b1 && (eth_mdio_o !== prev_o || eth_mdio_oe !== prev_oe) &&
          !(prev_mdc === 1'b1 && eth_mdc === 1'b0)) edge_bad++;
      if (active && op_done === 1'b1) done_count++;
      eth_mdio_i = (active && phy_present) ? phy_bit(fall_count - 1, phy_data) : 1'b1;
    end
    prev_mdc = eth_mdc;
    prev_o   = eth_mdio_o;
    prev_oe  = eth_mdio_oe;
    prev_rst = rst_n;
    cyc++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic [4:0] pa, input logic [4:0] ra,
                               input logic [15:0] wd, input logic phy, input logic [15:0] pd,
                               input bit now);
    if (!now) begin
      @(posedge clk); #2;
    end
    op_rh_wl    = rd;
    phy_addr    = pa;
    op_addr     = ra;
    op_wr_data  = wd;
    phy_present = phy;
    phy_data    = pd;
    op_exec     = 1'b1;
    @(posedge clk); #2;
    op_exec    = 1'b0;
    op_rh_wl   = ~rd;
    phy_addr   = 5'($urandom);
    op_addr    = 5'($urandom);
    op_wr_data = 16'($urandom);
    frame_id++;
  endtask

  task automatic waitFall(input int target, input string tag);
    int n = 0;
    while (fall_count < target && n < 4000) begin
      @(posedge clk); #2;
      n++;
    end
    if (fall_count < target) checkOutput({tag, "_wait_timeout"}, 64'(fall_count), 64'(target));
  endtask

  task automatic pulseBusy;
    op_rh_wl   = 1'($urandom);
    phy_addr   = 5'($urandom);
    op_addr    = 5'($urandom);
    op_wr_data = 16'($urandom);
    op_exec    = 1'b1;
    @(posedge clk); #2;
    op_exec    = 1'b0;
  endtask

  // Runs one operation and checks the wire image and results against the model.
  task automatic doOp(input logic rd, input logic [4:0] pa, input logic [4:0] ra,
                      input logic [15:0] wd, input logic phy, input logic [15:0] pd,
                      input string tag, input bit disturb, input bit now);
    logic [63:0] exp_bits;
    logic [63:0] exp_oe;
    int n;
    applyStimulus(rd, pa, ra, wd, phy, pd, now);
    if (disturb) begin
      waitFall(11, tag);
      pulseBusy();
      waitFall(41, tag);
      pulseBusy();
    end
    n = 0;
    while (op_done !== 1'b1 && n < 7000) begin
      @(posedge clk); #2;
      n++;
    end
    checkOutput({tag, "_done_seen"}, 64'(op_done), 64'(1));
    exp_bits = {{PRE{1'b1}}, 2'b01, (rd ? 2'b10 : 2'b01), pa, ra, 2'b10, wd};
    exp_oe   = rd ? {{(PRE + 14){1'b1}}, {18{1'b0}}} : {64{1'b1}};
    if (rd) begin
      exp_rd_ack  = phy ? 1'b0 : 1'b1;
      exp_rd_data = phy ? pd : 16'hFFFF;
    end else begin
      exp_rd_ack = 1'b0;
    end
    checkOutput({tag, "_oe"}, obs_oe, exp_oe);
    checkOutput({tag, "_bits"}, obs_o & exp_oe, exp_bits & exp_oe);
    checkOutput({tag, "_rd_data"}, 64'(op_rd_data), 64'(exp_rd_data));
    checkOutput({tag, "_rd_ack"}, 64'(op_rd_ack), 64'(exp_rd_ack));
    @(posedge clk); #2;
    checkOutput({tag, "_done_low"}, 64'(op_done), 64'(0));
    checkOutput({tag, "_done_count"}, 64'(done_count), 64'(1));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_mdc"}, 64'(eth_mdc), 64'(1));
    checkOutput({tag, "_o"}, 64'(eth_mdio_o), 64'(1));
    checkOutput({tag, "_oe"}, 64'(eth_mdio_oe), 64'(0));
    checkOutput({tag, "_done"}, 64'(op_done), 64'(0));
    checkOutput({tag, "_rd_data"}, 64'(op_rd_data), 64'(16'h0000));
    checkOutput({tag, "_rd_ack"}, 64'(op_rd_ack), 64'(1));
  endtask

  initial begin
    rst_n       = 1'b0;
    op_exec     = 1'b0;
    op_rh_wl    = 1'b0;
    phy_addr    = '0;
    op_addr     = '0;
    op_wr_data  = '0;
    exp_rd_data = 16'h0000;
    exp_rd_ack  = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checkResetValues("reset");
    rst_n = 1'b1;

    doOp(1'b0, 5'd0, 5'h00, 16'hB100, 1'b0, 16'h0000, "write_b100", 1'b0, 1'b0);
    doOp(1'b1, 5'd1, 5'h02, 16'h0000, 1'b1, 16'h001C, "read_001c", 1'b0, 1'b0);
    doOp(1'b1, 5'd3, 5'h11, 16'h0000, 1'b0, 16'h0000, "read_nophy", 1'b0, 1'b0);
    doOp(1'b0, 5'h15, 5'h0A, 16'h5A3C, 1'b0, 16'h0000, "write_busy", 1'b1, 1'b0);
    doOp(1'b1, 5'h1F, 5'h1F, 16'h0000, 1'b1, 16'h8001, "b2b_first", 1'b0, 1'b0);
    doOp(1'b0, 5'h0E, 5'h13, 16'hC0DE, 1'b0, 16'h0000, "b2b_second", 1'b0, 1'b1);

    applyStimulus(1'b1, 5'h07, 5'h04, 16'h0000, 1'b1, 16'hA5A5, 1'b0);
    waitFall(51, "reset_mid");
    repeat ($urandom_range(0, 40)) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetValues("reset_mid");
    exp_rd_data = 16'h0000;
    exp_rd_ack  = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b1;
    doOp(1'b0, 5'h09, 5'h1B, 16'h1234, 1'b0, 16'h0000, "post_reset_wr", 1'b0, 1'b0);
    doOp(1'b1, 5'h02, 5'h01, 16'h0000, 1'b1, 16'h7E81, "post_reset_rd", 1'b0, 1'b0);

    for (int k = 0; k < 3; k++) begin
      doOp(1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 1'($urandom),
           16'($urandom), $sformatf("rand%0d", k), 1'b0, 1'b0);
    end

    checkOutput("mdc_seen", 64'(mdc_checks > 100), 64'(1));
    checkOutput("mdc_timing_errs", 64'(mdc_bad), 64'(0));
    checkOutput("drive_edge_errs", 64'(edge_bad), 64'(0));
    checkOutput("release_after_frame_errs", 64'(tail_bad), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
